gpr_bank: RTL and testbench

Parametrised general-purpose register bank for the datapath. It replaces the fixed 10×10-bit, single-write, tri-state-read register file. It adds:
- configurable width, depth and read-port count
- two prioritised write ports with same-cycle write-to-read bypass
- registered (1-cycle) reads with valid flags
- a per-register busy scoreboard so the control unit can stall on pending write-backs

---
 rtl/gpr_bank.sv | 141 ++++++++++++++
 tb/tb_gpr_bank.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_bank.sv
// gpr_bank: parametrised register bank with two prioritised write ports,
// write-first bypass into registered read ports, and a busy scoreboard
// that lets the control unit stall on pending write-backs.
module gpr_bank #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned DEPTH    = 10,
  parameter int unsigned AW       = 4,
  parameter int unsigned NREAD    = 3,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               wr_en,
  input  logic [2*AW-1:0]          wr_addr,
  input  logic [2*WIDTH-1:0]       wr_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  input  logic [NREAD-1:0]         rd_en,
  input  logic [NREAD*AW-1:0]      rd_addr,
  output logic [NREAD*WIDTH-1:0]   rd_data,
  output logic [NREAD-1:0]         rd_valid,
  output logic [NREAD-1:0]         rd_busy,
  output logic [NREAD-1:0]         rd_err,
  output logic [DEPTH-1:0]         busy,
  output logic [DEPTH*WIDTH-1:0]   dbg_regs
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DEPTH*WIDTH-1:0] regs_q;
  logic [1:0]             wr_ok_c;
  logic                   rsv_ok_c;
  logic [DEPTH-1:0]       hit0_c;
  logic [DEPTH-1:0]       hit1_c;
  logic [DEPTH-1:0]       rsv_hit_c;
  logic [DEPTH-1:0]       busy_rd_c;
  logic [NREAD*WIDTH-1:0] rd_data_c;
  logic [NREAD-1:0]       rd_busy_c;
  logic [NREAD-1:0]       rd_err_c;

  // Address lies inside the bank.
  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  // Address may be written or reserved (in range, not the hardwired zero register).
  function automatic logic writable(input logic [AW-1:0] a);
    return in_range(a) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Qualify write/reserve requests and decode them to one-hot register hits.
  always_comb begin
    wr_ok_c[0] = wr_en[0] && writable(wr_addr[0 +: AW]);
    wr_ok_c[1] = wr_en[1] && writable(wr_addr[AW +: AW]);
    rsv_ok_c   = rsv_en && writable(rsv_addr);
    hit0_c     = '0;
    hit1_c     = '0;
    rsv_hit_c  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit0_c[i]    = wr_ok_c[0] && (wr_addr[0 +: AW] == AW'(i));
      hit1_c[i]    = wr_ok_c[1] && (wr_addr[AW +: AW] == AW'(i));
      rsv_hit_c[i] = rsv_ok_c && (rsv_addr == AW'(i));
    end
    // Readers see write-back clears of this edge but not its new reservation.
    busy_rd_c = busy & ~(hit0_c | hit1_c);
  end

  // Per-port read result with write-first bypass; port 1 data has priority.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    rd_err_c  = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      rd_err_c[p] = !in_range(rd_addr[p*AW +: AW]);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (rd_addr[p*AW +: AW] == AW'(i)) begin
          rd_busy_c[p] = busy_rd_c[i];
          if (hit1_c[i]) begin
            rd_data_c[p*WIDTH +: WIDTH] = wr_data[WIDTH +: WIDTH];
          end else if (hit0_c[i]) begin
            rd_data_c[p*WIDTH +: WIDTH] = wr_data[0 +: WIDTH];
          end else begin
            rd_data_c[p*WIDTH +: WIDTH] = regs_q[i*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  // Register storage; port 1 overrides port 0 on a shared address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (hit1_c[i]) begin
          regs_q[i*WIDTH +: WIDTH] <= wr_data[WIDTH +: WIDTH];
        end else if (hit0_c[i]) begin
          regs_q[i*WIDTH +: WIDTH] <= wr_data[0 +: WIDTH];
        end
      end
    end
  end

  // Scoreboard: a reservation is newer than a same-edge write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (rsv_hit_c[i]) begin
          busy[i] <= 1'b1;
        end else if (hit0_c[i] || hit1_c[i]) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  // Read output registers; data and flags hold while a port is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= '0;
      rd_busy  <= '0;
      rd_err   <= '0;
    end else begin
      rd_valid <= rd_en;
      for (int unsigned p = 0; p < NREAD; p++) begin
        if (rd_en[p]) begin
          rd_data[p*WIDTH +: WIDTH] <= rd_data_c[p*WIDTH +: WIDTH];
          rd_busy[p]                <= rd_busy_c[p];
          rd_err[p]                 <= rd_err_c[p];
        end
      end
    end
  end

  assign dbg_regs = regs_q;

endmodule

// File: tb/tb_gpr_bank.sv
// tb_gpr_bank: drives two gpr_bank instances (ZERO_REG off/on) with the same
// directed and random traffic and compares them to a sequential reference model.
module tb_gpr_bank;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned DEPTH = 10;
  localparam int unsigned AW    = 4;
  localparam int unsigned NREAD = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [1:0]             wr_en;
  logic [2*AW-1:0]        wr_addr;
  logic [2*WIDTH-1:0]     wr_data;
  logic                   rsv_en;
  logic [AW-1:0]          rsv_addr;
  logic [NREAD-1:0]       rd_en;
  logic [NREAD*AW-1:0]    rd_addr;

  logic [NREAD*WIDTH-1:0] rd_data_o  [2];
  logic [NREAD-1:0]       rd_valid_o [2];
  logic [NREAD-1:0]       rd_busy_o  [2];
  logic [NREAD-1:0]       rd_err_o   [2];
  logic [DEPTH-1:0]       busy_o     [2];
  logic [DEPTH*WIDTH-1:0] dbg_o      [2];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, index 0 = ZERO_REG off, 1 = ZERO_REG on.
  logic [WIDTH-1:0] m_mem   [2][DEPTH];
  logic             m_busy  [2][DEPTH];
  logic [WIDTH-1:0] e_data  [2][NREAD];
  logic             e_valid [2][NREAD];
  logic             e_rbusy [2][NREAD];
  logic             e_err   [2][NREAD];

  always #5 clk = ~clk;

  gpr_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .NREAD(NREAD), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]), .rd_busy(rd_busy_o[0]),
    .rd_err(rd_err_o[0]), .busy(busy_o[0]), .dbg_regs(dbg_o[0])
  );

  gpr_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .NREAD(NREAD), .ZERO_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]), .rd_busy(rd_busy_o[1]),
    .rd_err(rd_err_o[1]), .busy(busy_o[1]), .dbg_regs(dbg_o[1])
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[z][i]  = '0;
        m_busy[z][i] = 1'b0;
      end
      for (int p = 0; p < NREAD; p++) begin
        e_data[z][p]  = '0;
        e_valid[z][p] = 1'b0;
        e_rbusy[z][p] = 1'b0;
        e_err[z][p]   = 1'b0;
      end
    end
  endtask

  // One clock edge as a sequential program: writes, then reads, then reserve.
  task automatic model_cycle();
    int a;
    for (int z = 0; z < 2; z++) begin
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k]) begin
          a = int'(wr_addr[k*AW +: AW]);
          if (a < DEPTH && !(z == 1 && a == 0)) begin
            m_mem[z][a]  = wr_data[k*WIDTH +: WIDTH];
            m_busy[z][a] = 1'b0;
          end
        end
      end
      for (int p = 0; p < NREAD; p++) begin
        e_valid[z][p] = rd_en[p];
        if (rd_en[p]) begin
          a = int'(rd_addr[p*AW +: AW]);
          if (a >= DEPTH) begin
            e_data[z][p]  = '0;
            e_rbusy[z][p] = 1'b0;
            e_err[z][p]   = 1'b1;
          end else begin
            e_data[z][p]  = m_mem[z][a];
            e_rbusy[z][p] = m_busy[z][a];
            e_err[z][p]   = 1'b0;
          end
        end
      end
      a = int'(rsv_addr);
      if (rsv_en && a < DEPTH && !(z == 1 && a == 0)) m_busy[z][a] = 1'b1;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [NREAD*WIDTH-1:0] xd;
    logic [NREAD-1:0]       xv, xb, xe;
    logic [DEPTH-1:0]       xbusy;
    logic [DEPTH*WIDTH-1:0] xdbg;
    for (int z = 0; z < 2; z++) begin
      for (int p = 0; p < NREAD; p++) begin
        xd[p*WIDTH +: WIDTH] = e_data[z][p];
        xv[p] = e_valid[z][p];
        xb[p] = e_rbusy[z][p];
        xe[p] = e_err[z][p];
      end
      for (int i = 0; i < DEPTH; i++) begin
        xbusy[i] = m_busy[z][i];
        xdbg[i*WIDTH +: WIDTH] = m_mem[z][i];
      end
      check($sformatf("%s.u%0d.rd_data", tag, z), 128'(rd_data_o[z]), 128'(xd));
      check($sformatf("%s.u%0d.rd_valid", tag, z), 128'(rd_valid_o[z]), 128'(xv));
      check($sformatf("%s.u%0d.rd_busy", tag, z), 128'(rd_busy_o[z]), 128'(xb));
      check($sformatf("%s.u%0d.rd_err", tag, z), 128'(rd_err_o[z]), 128'(xe));
      check($sformatf("%s.u%0d.busy", tag, z), 128'(busy_o[z]), 128'(xbusy));
      check($sformatf("%s.u%0d.dbg_regs", tag, z), 128'(dbg_o[z]), 128'(xdbg));
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
    rd_en = '0; rd_addr = '0;
  endtask

  task automatic set_wr(input int k, input int a, input int d);
    wr_en[k] = 1'b1;
    wr_addr[k*AW +: AW] = AW'(a);
    wr_data[k*WIDTH +: WIDTH] = WIDTH'(d);
  endtask

  task automatic set_rd(input int p, input int a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  // Called at posedge+1; leaves the bench at the next posedge+1.
  task automatic step(input string tag);
    model_cycle();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  // Asynchronous reset pulse inside a cycle; outputs must clear with no clock.
  task automatic async_reset_check(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    #1 rst = 1'b0;
  endtask

  function automatic int rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 5) return int'($urandom_range(0, 3));
    if (r < 8) return int'($urandom_range(0, 9));
    return int'($urandom_range(10, 15));
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all("init");

    // Preload every register to all-ones with reservations outstanding.
    for (int r = 0; r < 5; r++) begin
      idle();
      set_wr(0, 2*r, 'h3FF);
      set_wr(1, 2*r + 1, 'h3FF);
      rsv_en = 1'b1; rsv_addr = AW'(9 - 2*r);
      step("preload");
    end
    idle();
    set_rd(0, 1); set_rd(1, 2); set_rd(2, 8);
    step("preload_rd");
    async_reset_check("reset");
    check("reset.u0.dbg_regs", 128'(dbg_o[0]), 128'(0));
    check("reset.u0.rd_data", 128'(rd_data_o[0]), 128'(0));

    // Two writes to one register: port 1 wins.
    idle();
    set_wr(0, 3, 'h155); set_wr(1, 3, 'h0AA);
    step("wr_prio");
    idle();
    set_rd(0, 3); set_wr(0, 4, 'h044);
    step("rd_prio");
    check("rd_prio.data", 128'(rd_data_o[0][0 +: WIDTH]), 128'('h0AA));
    check("rd_prio.valid", 128'(rd_valid_o[0][0]), 128'(1));

    // Write-first bypass on port 2, stored value on port 0.
    idle();
    set_wr(0, 5, 'h123); set_rd(2, 5); set_rd(0, 4);
    step("bypass");
    check("bypass.p2", 128'(rd_data_o[0][2*WIDTH +: WIDTH]), 128'('h123));
    check("bypass.p0", 128'(rd_data_o[0][0 +: WIDTH]), 128'('h044));

    // Scoreboard: reserve, observe, clear by write, then reserve beats write.
    idle();
    rsv_en = 1'b1; rsv_addr = AW'(7);
    step("rsv");
    idle();
    set_rd(1, 7);
    step("rsv_rd");
    check("rsv_rd.rd_busy", 128'(rd_busy_o[0][1]), 128'(1));
    idle();
    set_wr(0, 7, 'h0F0);
    step("rsv_clr");
    check("rsv_clr.busy7", 128'(busy_o[0][7]), 128'(0));
    idle();
    set_wr(1, 7, 'h0F1); rsv_en = 1'b1; rsv_addr = AW'(7);
    step("rsv_wr");
    check("rsv_wr.busy7", 128'(busy_o[0][7]), 128'(1));

    // Out-of-range read and write.
    idle();
    set_rd(0, 12); set_wr(0, 15, 'h3FF);
    step("oor");
    check("oor.data", 128'(rd_data_o[0][0 +: WIDTH]), 128'(0));
    check("oor.err", 128'(rd_err_o[0][0]), 128'(1));

    // Register 0 write and read on both variants.
    idle();
    set_wr(0, 0, 'h2AA);
    step("zero_wr");
    idle();
    set_rd(0, 0);
    step("zero_rd");
    check("zero_rd.u1", 128'(rd_data_o[1][0 +: WIDTH]), 128'(0));
    check("zero_rd.u0", 128'(rd_data_o[0][0 +: WIDTH]), 128'('h2AA));

    // Reset held across the edge that would complete a read.
    idle();
    set_rd(0, 3); set_rd(1, 5); set_rd(2, 0);
    step("pre_rst_rd");
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    compare_all("rst_rd");
    check("rst_rd.valid", 128'(rd_valid_o[1]), 128'(0));
    check("rst_rd.data", 128'(rd_data_o[0]), 128'(0));
    rst = 1'b0;

    // Random traffic with collisions biased in.
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 2) != 0) set_wr(k, rand_addr(), int'($urandom));
      end
      if ($urandom_range(0, 2) == 0) begin
        rsv_en = 1'b1;
        rsv_addr = AW'(rand_addr());
      end
      for (int p = 0; p < NREAD; p++) begin
        if ($urandom_range(0, 3) != 0) set_rd(p, rand_addr());
      end
      step("rand");
      if (n == 250) async_reset_check("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
